region_addr_gen: RTL and testbench



---
 rtl/region_addr_gen.sv | 152 +++++++++++++++
 tb/tb_region_addr_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/region_addr_gen.sv
// Streams the inclusive word-address range of the lowest-indexed table entry
// whose file range contains the requested file index.
module region_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int FILE_W    = 16,
  parameter int N_REGIONS = 16,
  parameter int IDX_W     = $clog2(N_REGIONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [FILE_W-1:0] cfg_file_lo,
  input  logic [FILE_W-1:0] cfg_file_hi,
  input  logic [ADDR_W-1:0] cfg_mem_start,
  input  logic [ADDR_W-1:0] cfg_mem_end,
  input  logic              cfg_clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FILE_W-1:0] req_file,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic [IDX_W-1:0]  hit_idx,
  output logic              err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both 1; valid and its payload hold steady until that edge.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_STREAM = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGIONS - 1);

  state_t state, state_nxt;

  logic [N_REGIONS-1:0] ent_valid;
  logic [FILE_W-1:0]    ent_lo    [N_REGIONS];
  logic [FILE_W-1:0]    ent_hi    [N_REGIONS];
  logic [ADDR_W-1:0]    ent_start [N_REGIONS];
  logic [ADDR_W-1:0]    ent_end   [N_REGIONS];

  logic [FILE_W-1:0] file_q;
  logic [IDX_W-1:0]  ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] end_q;
  logic              hit;
  logic              range_ok;
  logic              at_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_valid <= '0;
    end else if (cfg_clr) begin
      ent_valid <= '0;
    end else if (cfg_we) begin
      ent_valid[cfg_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && !cfg_clr) begin
      ent_lo[cfg_idx]    <= cfg_file_lo;
      ent_hi[cfg_idx]    <= cfg_file_hi;
      ent_start[cfg_idx] <= cfg_mem_start;
      ent_end[cfg_idx]   <= cfg_mem_end;
    end
  end

  assign hit      = ent_valid[ptr] && (ent_lo[ptr] <= file_q) && (file_q <= ent_hi[ptr]);
  assign range_ok = ent_start[ptr] <= ent_end[ptr];
  // Last-beat test precedes the increment, so an end of all-ones never wraps.
  assign at_end   = cnt == end_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_SEARCH;
      S_SEARCH: begin
        if (hit) begin
          state_nxt = range_ok ? S_STREAM : S_ERR;
        end else if (ptr == LAST_IDX) begin
          state_nxt = S_ERR;
        end
      end
      S_STREAM: if (addr_ready && at_end) state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = state == S_IDLE;
    addr_valid = state == S_STREAM;
    addr_last  = (state == S_STREAM) && at_end;
    err        = state == S_ERR;
    busy       = state != S_IDLE;
  end

  assign addr      = cnt;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      file_q  <= '0;
      ptr     <= '0;
      cnt     <= '0;
      end_q   <= '0;
      hit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            file_q <= req_file;
            ptr    <= '0;
          end
        end
        S_SEARCH: begin
          if (hit) begin
            hit_idx <= ptr;
            cnt     <= ent_start[ptr];
            end_q   <= ent_end[ptr];
          end else if (ptr == LAST_IDX) begin
            hit_idx <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_STREAM: begin
          if (addr_ready && !at_end) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_region_addr_gen.sv
// Randomized and directed checks of region_addr_gen against a table-lookup
// model that derives the expected address list and event cycle directly.
module tb_region_addr_gen;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [15:0] cfg_file_lo = '0, cfg_file_hi = '0;
  logic [15:0] cfg_mem_start = '0, cfg_mem_end = '0;
  logic        cfg_clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_file = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [15:0] addr;
  logic        addr_last;
  logic [3:0]  hit_idx;
  logic        err;
  logic        busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  bit m_valid [N];
  int m_lo [N], m_hi [N], m_start [N], m_end [N];
  logic [15:0] exp_q [$];

  region_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_file_lo(cfg_file_lo), .cfg_file_hi(cfg_file_hi),
    .cfg_mem_start(cfg_mem_start), .cfg_mem_end(cfg_mem_end),
    .cfg_clr(cfg_clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_file(req_file), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_last(addr_last), .hit_idx(hit_idx), .err(err),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cfg_write(input int idx, input int lo, input int hi, input int s, input int e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[3:0];
    cfg_file_lo = lo[15:0]; cfg_file_hi = hi[15:0];
    cfg_mem_start = s[15:0]; cfg_mem_end = e[15:0];
    m_valid[idx] = 1'b1; m_lo[idx] = lo; m_hi[idx] = hi; m_start[idx] = s; m_end[idx] = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  function automatic int lookup(input int f);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && f >= m_lo[i] && f <= m_hi[i]) return i;
    return -1;
  endfunction

  // mode 0: always ready, 1: random ready, 2: fixed 1,0,0,1,0,1 pattern.
  task automatic do_req(input int f, input int mode, input bit rewrite);
    int k, cyc, iters, len;
    bit bad, rdy;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    k = lookup(f);
    bad = (k < 0) || (m_start[k] > m_end[k]);
    exp_q.delete();
    if (!bad) for (int a = m_start[k]; a <= m_end[k]; a++) exp_q.push_back(a[15:0]);
    len = exp_q.size();
    @(negedge clk);
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_file = f[15:0];
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!addr_valid && !err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("first_event_cycle", cyc, (k < 0) ? N + 1 : k + 2);
    check("err_flag", err, bad);
    check("hit_idx", hit_idx, (k < 0) ? 0 : k);
    if (bad) begin
      @(negedge clk);
      check("err_one_cycle", err, 0);
      check("req_ready_after_err", req_ready, 1);
      check("no_addr_after_err", addr_valid, 0);
      return;
    end
    iters = 0;
    while (exp_q.size() > 0 && iters < 2000) begin
      check("addr_valid", addr_valid, 1);
      check("addr", addr, exp_q[0]);
      check("addr_last", addr_last, exp_q.size() == 1);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = $urandom_range(0, 1) == 1;
      else rdy = (iters < 6) ? pat[iters] : 1'b1;
      addr_ready = rdy;
      if (rewrite && iters == 2) begin
        cfg_we = 1'b1; cfg_idx = k[3:0];
        cfg_file_lo = 16'd1; cfg_file_hi = 16'd32;
        cfg_mem_start = 16'd5000; cfg_mem_end = 16'd5001;
        m_lo[k] = 1; m_hi[k] = 32; m_start[k] = 5000; m_end[k] = 5001;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      iters++;
    end
    addr_ready = 1'b0;
    cfg_we = 1'b0;
    if (mode == 0) check("stream_cycles", iters, len);
    check("req_ready_after_stream", req_ready, 1);
    check("idle_addr_valid", addr_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_addr_valid"}, addr_valid, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_addr_last"}, addr_last, 0);
    check({tag, "_hit_idx"}, hit_idx, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    clear_model();
    for (int i = 0; i < N; i++) begin
      m_lo[i] = 0; m_hi[i] = 0; m_start[i] = 0; m_end[i] = 0;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    cfg_write(0, 0, 0, 0, 783);
    cfg_write(1, 1, 32, 784, 808);
    do_req(5, 0, 1'b0);
    do_req(999, 0, 1'b0);

    cfg_write(2, 40, 50, 10, 12);
    cfg_write(3, 45, 45, 20, 20);
    do_req(45, 1, 1'b0);

    cfg_write(4, 60, 60, 100, 102);
    do_req(60, 2, 1'b0);

    cfg_write(5, 70, 70, 65535, 65535);
    do_req(70, 0, 1'b0);
    cfg_write(6, 80, 80, 9, 3);
    do_req(80, 0, 1'b0);

    do_req(5, 0, 1'b1);
    do_req(5, 0, 1'b0);

    // cfg_clr and cfg_we in the same cycle: clear must win.
    @(negedge clk);
    cfg_clr = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd2;
    cfg_file_lo = 16'd45; cfg_file_hi = 16'd45;
    cfg_mem_start = 16'd1; cfg_mem_end = 16'd2;
    clear_model();
    @(negedge clk);
    cfg_clr = 1'b0; cfg_we = 1'b0;
    do_req(45, 0, 1'b0);

    // Reset during the third beat of a stream.
    cfg_write(1, 1, 32, 784, 808);
    @(negedge clk);
    req_valid = 1'b1; req_file = 16'd5;
    @(negedge clk);
    req_valid = 1'b0;
    addr_ready = 1'b1;
    begin
      int guard = 0;
      while (!addr_valid && guard < 40) begin
        @(negedge clk);
        guard++;
      end
    end
    repeat (2) @(negedge clk);
    check("beat3_addr", addr, 786);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    addr_ready = 1'b0;
    clear_model();
    check_reset_outputs("midreset");
    do_req(5, 0, 1'b0);

    for (int i = 0; i < N; i++) begin
      int lo, s, e;
      lo = $urandom_range(0, 40);
      s = $urandom_range(1, 1000);
      e = ($urandom_range(0, 7) == 0) ? s - 1 : s + $urandom_range(0, 12);
      if ($urandom_range(0, 3) != 0) cfg_write(i, lo, lo + $urandom_range(0, 8), s, e);
    end
    for (int r = 0; r < 25; r++) do_req($urandom_range(0, 55), 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
